// File: rtl/mux_collect_8_1.sv
// 8-to-1 round-robin collector: merges eight request lanes onto one registered
// valid/ready output stream, tagging each word with its lane index and acking the lane.
module mux_collect_8_1 #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] din,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  output logic [7:0]          ack
);

  logic [2:0]        ptr;
  logic [2:0]        idx;
  logic [2:0]        grant_idx;
  logic              found;
  logic              free;
  logic [DATA_W-1:0] grant_data;

  assign free = !out_valid || out_ready;

  // First requesting lane found scanning upward from ptr, wrapping mod 8.
  always_comb begin
    found     = 1'b0;
    grant_idx = 3'd0;
    idx       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_data = din[grant_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ack       <= 8'h00;
      ptr       <= 3'd0;
    end else if (free) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        ack       <= 8'h01 << grant_idx;
        ptr       <= grant_idx + 3'd1;
      end else begin
        out_valid <= 1'b0;
        ack       <= 8'h00;
      end
    end else begin
      // Stalled: hold the presented word, capture nothing.
      ack <= 8'h00;
    end
  end

endmodule

// File: doc/mux_collect_8_1.md
Name: mux_collect_8_1

Overview:
- 8-to-1 collector. It gathers words from eight request lanes onto one output stream.
- It is the gathering end of the 1-to-8 steering path: a demux fans one source out by `sel`; this block merges eight sources back and tags each word with its lane code.
- Arbitration is round-robin. The output register uses a valid/ready handshake, and each accepted lane gets a one-cycle ack.

Parameters:
- DATA_W, 1, bit width of each lane's data word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-lane request; bit k high means lane k presents a word.
- din  input  8*DATA_W  lane data, flattened; lane k occupies din[k*DATA_W +: DATA_W].
- out_ready  input  1  downstream ready to accept.
- out_valid  output  1  out_data/out_sel hold a valid word.
- out_data  output  DATA_W  collected word.
- out_sel  output  3  lane index (0..7) of out_data.
- ack  output  8  one-hot, one-cycle pulse; bit k means lane k's word was captured this edge.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values (async, immediate): out_valid=0, out_data=0, out_sel=0, ack=0, internal pointer ptr=0.
- Slot-free condition: free = !out_valid || out_ready.
- Grant when free and req != 0:
  - Select the lane k: the first set req bit found scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (wraps mod 8).
  - At the edge: out_data<=lane k data, out_sel<=k, out_valid<=1, ack<=(1<<k), ptr<=(k+1) mod 8.
- Free and req == 0: out_valid<=0, ack<=0, ptr unchanged. out_data/out_sel keep their last values; they are don't-care while out_valid=0.
- Stall (out_valid && !out_ready):
  - out_valid, out_data, out_sel held stable.
  - ack<=0, ptr unchanged, no lane captured.
- Transfer: occurs on an edge where out_valid && out_ready. Refill in the same edge is allowed, giving 1 word/cycle sustained throughput.
- Latency: req/din sampled at edge N appear on out_* after edge N, i.e. 1 cycle.
- ack is registered, so it is visible in the cycle after capture, aligned with out_valid rising for that word.
- Lane protocol:
  - A lane keeps req and din stable until it sees its ack bit.
  - If req is still high in the ack cycle, that is a new word and is eligible again under round-robin.
- Fairness: with all 8 lanes requesting continuously and out_ready=1, the grant order is 0,1,2,...,7,0,... Any lane waits at most 7 grants.
- Single requester: a lone active lane is granted every free cycle regardless of ptr.
- Wrap-around: after granting lane 7, ptr returns to 0.
- Reset mid-operation: any held word is discarded (out_valid drops immediately), pending acks are cleared, and ptr returns to 0. Lanes re-present after reset.
- No combinational path from req/din/out_ready to any output; all outputs are registered.

Test Plan:
- Reset hold: rst_n=0 with req=8'hFF → out_valid=0, ack=0, out_sel=0 throughout. Release rst_n → first grant is lane 0 (ack=8'h01, out_sel=0).
- Round-robin sweep: DATA_W=1, req=8'hFF, din=8'b1010_0101, out_ready=1 → over 8 cycles out_sel=0..7, out_data=1,0,1,0,0,1,0,1. ack walks 01,02,04,...,80, then lane 0 repeats.
- Skip and wrap: ptr=6, req=8'b0000_0101 → grants lane 0, then lane 2, then lane 0. Lanes 1, 3-7 never acked.
- Backpressure: grant lane 3 then out_ready=0 for 4 cycles with req=8'hFF → out_sel=3 and out_data held for 4 cycles, ack=0. On out_ready=1, the next edge grants lane 4.
- Idle drain: one word from lane 5, then req=0 with out_ready=1 → out_valid drops 1 cycle after the transfer. ptr stays 6, so a later req=8'hFF grants lane 6 first.
- Async reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 between edges → out_valid=0 and ack=0 immediately, before the next clk edge. After release, the grant restarts at lane 0.
